// File: rtl/mem_stage_pkg.sv
// Shared layout of the EX/MEM and MEM/WB buses, fun_3 codes and MEM-stage FSM states.
package mem_stage_pkg;

    localparam int EX_W = 76;
    localparam int WB_W = 38;

    // EX/MEM bus field positions (LSB of each field)
    localparam int EX_ALU_LSB   = 0;
    localparam int EX_DATA2_LSB = 32;
    localparam int EX_FUN3_LSB  = 64;
    localparam int EX_DW_BIT    = 67;
    localparam int EX_DR_BIT    = 68;
    localparam int EX_WADDR_LSB = 69;
    localparam int EX_WREN_BIT  = 74;
    localparam int EX_MUX_BIT   = 75;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic { IDLE = 1'b0, ACCESS = 1'b1 } state_t;

    typedef struct packed {
        logic        mux_d_mem;
        logic        write_reg_en;
        logic [4:0]  write_address;
        logic        d_mem_r;
        logic        d_mem_w;
        logic [2:0]  fun_3;
        logic [31:0] data_2;
        logic [31:0] alu_result;
    } ex_bus_t;

    typedef struct packed {
        logic        write_reg_en;
        logic [4:0]  write_address;
        logic [31:0] wb_data;
    } wb_bus_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data memory / data cache request bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteen;
    logic        mem_busywait;
    logic [31:0] mem_readdata;

    modport master (
        output mem_read, mem_write, mem_address, mem_writedata, mem_byteen,
        input  mem_busywait, mem_readdata
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_writedata, mem_byteen,
        output mem_busywait, mem_readdata
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] readdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  fun_3,
    output logic [31:0] data
);
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = readdata >> {offset, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = offset[1] ? readdata[31:16] : readdata[15:0];

    always_comb begin
        data = readdata;
        case (fun_3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LHU:  data = {16'h0, half_sel};
            default: data = readdata;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store handshake with data memory, load alignment, MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EX_W = mem_stage_pkg::EX_W,
    parameter int WB_W = mem_stage_pkg::WB_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [EX_W-1:0]  ex_out,
    mem_stage_if.master      bus,
    output logic             stall,
    output logic             mem_misaligned,
    output logic [WB_W-1:0]  mem_out
);
    ex_bus_t     ex;
    state_t      state;
    wb_bus_t     out_q;
    logic        rd_q, wr_q, mis_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic        access, is_half, is_word, misaligned, req, is_read;
    logic [31:0] load_data, wb_data, wdata_n;
    logic [3:0]  be_n;

    assign ex = ex_out;

    // Size comes from fun_3[1:0]: 00 byte, 01 half, anything else is treated as a word.
    assign access     = ex.d_mem_r | ex.d_mem_w;
    assign is_half    = ex.fun_3[1:0] == 2'b01;
    assign is_word    = ex.fun_3[1];
    assign misaligned = access & ((is_half & ex.alu_result[0]) |
                                  (is_word & (|ex.alu_result[1:0])));
    assign req        = access & ~misaligned;
    assign is_read    = ex.d_mem_r;

    assign stall = ((state == IDLE) & req) | ((state == ACCESS) & bus.mem_busywait);

    mem_load_align u_align (
        .readdata (bus.mem_readdata),
        .offset   (ex.alu_result[1:0]),
        .fun_3    (ex.fun_3),
        .data     (load_data)
    );

    assign wb_data = ex.mux_d_mem ? load_data : ex.alu_result;

    always_comb begin
        wdata_n = ex.data_2;
        be_n    = 4'b1111;
        case (ex.fun_3[1:0])
            2'b00: begin
                wdata_n = {4{ex.data_2[7:0]}};
                be_n    = 4'b0001 << ex.alu_result[1:0];
            end
            2'b01: begin
                wdata_n = {2{ex.data_2[15:0]}};
                be_n    = 4'b0011 << ex.alu_result[1:0];
            end
            default: begin
                wdata_n = ex.data_2;
                be_n    = 4'b1111;
            end
        endcase
        if (is_read) be_n = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            mis_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            mis_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= ACCESS;
                        rd_q    <= is_read;
                        wr_q    <= ~is_read;
                        addr_q  <= {ex.alu_result[31:2], 2'b00};
                        wdata_q <= wdata_n;
                        be_q    <= be_n;
                        out_q   <= '0;
                    end else begin
                        // Misaligned accesses fall through here with the register write suppressed.
                        mis_q <= misaligned;
                        out_q <= '{write_reg_en:  ex.write_reg_en & ~misaligned,
                                   write_address: ex.write_address,
                                   wb_data:       ex.alu_result};
                    end
                end
                ACCESS: begin
                    if (!bus.mem_busywait) begin
                        state <= IDLE;
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                        be_q  <= '0;
                        out_q <= '{write_reg_en:  ex.write_reg_en,
                                   write_address: ex.write_address,
                                   wb_data:       wb_data};
                    end else begin
                        out_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read      = rd_q;
    assign bus.mem_write     = wr_q;
    assign bus.mem_address   = addr_q;
    assign bus.mem_writedata = wdata_q;
    assign bus.mem_byteen    = be_q;
    assign mem_misaligned    = mis_q;
    assign mem_out           = out_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a behavioural load/store model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [75:0] ex_out;
    logic        stall, mem_misaligned;
    logic [37:0] mem_out;
    int          n_chk = 0;
    int          n_pass = 0;

    mem_stage_if mif ();

    mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ex_out         (ex_out),
        .bus            (mif),
        .stall          (stall),
        .mem_misaligned (mem_misaligned),
        .mem_out        (mem_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [2:0] f3);
        logic [31:0] b, h;
        b = (rdata >> (8 * addr[1:0])) & 32'hFF;
        h = (rdata >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    // One instruction through the stage; busy = number of ACCESS cycles with busywait held high.
    task automatic run_op(input logic mux, input logic wre, input logic [4:0] wa,
                          input logic r, input logic w, input logic [2:0] f3,
                          input logic [31:0] d2, input logic [31:0] alu,
                          input int busy, input logic [31:0] rdata);
        int          sz, off;
        logic        mis, req;
        logic [31:0] wb, wd;
        logic [3:0]  be;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(alu[1:0]);
        mis = (r | w) && (off % sz != 0);
        req = (r | w) && !mis;
        if (sz == 1) begin wd = (d2 & 32'hFF) * 32'h01010101;   be = 4'(1 << off); end
        else if (sz == 2) begin wd = (d2 & 32'hFFFF) * 32'h00010001; be = 4'(3 << off); end
        else begin wd = d2; be = 4'hF; end
        ex_out = {mux, wre, wa, r, w, f3, d2, alu};
        mif.mem_busywait = 1'($urandom_range(0, 1));
        mif.mem_readdata = $urandom;
        #1;
        chk("stall_idle", stall, req);
        if (!req) begin
            @(posedge clk); #1;
            chk("out_nomem", mem_out, {wre & ~mis, wa, alu});
            chk("misaligned", mem_misaligned, mis);
            chk("rd_idle", mif.mem_read, 1'b0);
            chk("wr_idle", mif.mem_write, 1'b0);
        end else begin
            @(posedge clk); #1;
            chk("rd_strobe", mif.mem_read, r);
            chk("wr_strobe", mif.mem_write, !r);
            chk("addr", mif.mem_address, alu & 32'hFFFFFFFC);
            chk("byteen", mif.mem_byteen, r ? 4'h0 : be);
            if (!r) chk("wdata", mif.mem_writedata, wd);
            chk("bubble0", mem_out, 38'h0);
            chk("mis_req", mem_misaligned, 1'b0);
            for (int k = 0; k < busy; k++) begin
                mif.mem_busywait = 1'b1;
                mif.mem_readdata = $urandom;
                #1;
                chk("stall_busy", stall, 1'b1);
                @(posedge clk); #1;
                chk("bubble", mem_out, 38'h0);
                chk("strobe_hold", {mif.mem_read, mif.mem_write}, {r, !r});
                chk("addr_hold", mif.mem_address, alu & 32'hFFFFFFFC);
            end
            mif.mem_busywait = 1'b0;
            mif.mem_readdata = rdata;
            #1;
            chk("stall_done", stall, 1'b0);
            @(posedge clk); #1;
            wb = mux ? model_load(rdata, alu, f3) : alu;
            chk("out_mem", mem_out, {wre, wa, wb});
            chk("strobe_drop", {mif.mem_read, mif.mem_write}, 2'b00);
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic        r, w;
        reset = 1'b1;
        ex_out = '0;
        mif.mem_busywait = 1'b0;
        mif.mem_readdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", mif.mem_read, 1'b0);
        chk("rst_wr", mif.mem_write, 1'b0);
        chk("rst_out", mem_out, 38'h0);
        chk("rst_mis", mem_misaligned, 1'b0);
        reset = 1'b0;

        run_op(1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 3'd2, 32'h0, 32'h1234, 0, 32'h0);
        run_op(1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 3'd2, 32'h0, 32'h100, 3, 32'hDEADBEEF);
        run_op(1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 3'd0, 32'h0, 32'h103, 1, 32'h80FF0011);
        run_op(1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 3'd4, 32'h0, 32'h103, 0, 32'h80FF0011);
        run_op(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 3'd1, 32'h0000ABCD, 32'h202, 2, 32'h0);
        run_op(1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 3'd2, 32'h0, 32'h101, 0, 32'h0);
        run_op(1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 3'd1, 32'h5555, 32'h306, 1, 32'h8001_7FFF);

        // Reset arriving in the second ACCESS cycle abandons the access.
        ex_out = {1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 3'd2, 32'h0, 32'h400};
        mif.mem_busywait = 1'b1;
        @(posedge clk); #1;
        chk("rst_pre_rd", mif.mem_read, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_acc_rd", mif.mem_read, 1'b0);
        chk("rst_acc_out", mem_out, 38'h0);
        chk("rst_acc_idle", stall, 1'b1);
        reset = 1'b0;
        run_op(1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 3'd2, 32'h0, 32'h400, 1, 32'hCAFEF00D);

        for (int i = 0; i < 150; i++) begin
            r = 1'b0; w = 1'b0;
            case ($urandom_range(0, 3))
                0:       begin r = 1'b0; w = 1'b0; end
                1:       r = 1'b1;
                2:       w = 1'b1;
                default: begin r = 1'b1; w = 1'($urandom_range(0, 1)); end
            endcase
            if (w && !r) begin
                case ($urandom_range(0, 2))
                    0: f3 = 3'd0; 1: f3 = 3'd1; default: f3 = 3'd2;
                endcase
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
                endcase
            end
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
                   r, w, f3, $urandom, $urandom, $urandom_range(0, 3), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the 76-bit EX/MEM bus (`ex_out`) and runs the data-memory/data-cache access handshake for loads and stores.
- Aligns and extends load data, selects the write-back value, and registers the 38-bit MEM/WB bus for the WB stage.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- EX_W, 76, width of incoming EX/MEM bus
- WB_W, 38, width of outgoing MEM/WB bus

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- ex_out  in  76  {mux_d_mem[75], write_reg_en[74], write_address[73:69], d_mem_r[68], d_mem_w[67], fun_3[66:64], data_2[63:32], alu_result[31:0]}
- mem_busywait  in  1  data memory/cache busy; low = current request completes this cycle
- mem_readdata  in  32  word read from memory, valid in the cycle mem_busywait is low
- mem_read  out  1  registered read strobe
- mem_write  out  1  registered write strobe
- mem_address  out  32  word address {alu_result[31:2],2'b00}
- mem_writedata  out  32  store data, lane-replicated
- mem_byteen  out  4  byte enables for the store
- stall  out  1  hold EX/MEM bus and all earlier stages
- mem_misaligned  out  1  one-cycle pulse on a misaligned access
- mem_out  out  38  {write_reg_en[37], write_address[36:32], wb_data[31:0]}

Behaviour:
- Reset:
  - state=IDLE; mem_read=0, mem_write=0, mem_out=0, mem_misaligned=0.
  - Reset during ACCESS drops the strobes at that edge; the access is abandoned.
- Access request: req = (d_mem_r | d_mem_w) & ~misaligned.
  - If d_mem_r and d_mem_w are both set, the access is a read and the write is ignored.
- Misaligned:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- FSM, two states:
  - IDLE:
    - If req: register strobes high, go to ACCESS, stall=1, load a bubble (0) into mem_out.
    - Otherwise: no memory access; mem_out <= {write_reg_en, write_address, alu_result}, taken in the same edge, so latency is 1 cycle.
  - ACCESS:
    - Strobes and address stay constant.
    - While mem_busywait=1: stall=1 and mem_out is loaded with a bubble.
    - When mem_busywait=0: stall=0; mem_out <= {write_reg_en, write_address, wb_data}; strobes drop; go to IDLE.
  - Minimum memory-op latency is 2 cycles.
- stall is combinational = (IDLE & req) | (ACCESS & mem_busywait). Upstream holds ex_out stable while stall=1.
- wb_data = mux_d_mem ? load_data : alu_result.
- Load extraction from mem_readdata, using byte offset addr[1:0]:
  - 000 LB: sign-extend selected byte.
  - 001 LH: sign-extend halfword at addr[1].
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extend.
  - Other fun_3 values: word.
- Store:
  - SB (000): mem_writedata = {4{byte}}; mem_byteen = 0001<<addr[1:0].
  - SH (001): mem_writedata = {2{half}}; mem_byteen = 0011<<addr[1:0].
  - SW (010): mem_writedata = word; mem_byteen = 1111.
  - mem_byteen is 0000 on reads.
- Misaligned access:
  - No strobes, no stall.
  - mem_misaligned pulses 1 cycle.
  - mem_out gets write_reg_en forced to 0.
- mem_busywait is ignored in IDLE.
- mem_readdata is sampled only in the completion cycle.

Decomposition:
- Package mem_stage_pkg:
  - EX bus field offsets/widths.
  - fun_3 codes (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - FSM state enum (IDLE, ACCESS).
  - WB bus layout.
- One sub-module, mem_load_align: combinational byte/half select plus sign/zero extend (inputs: readdata, offset, fun_3).
- Store lane logic stays inline.

Test Plan:
- ALU op (mux_d_mem=0, write_reg_en=1, rd=5, alu=0x1234, no mem) -> next cycle mem_out={1,5,0x00001234}; stall never asserted.
- LW at 0x100 with mem_busywait high for 3 ACCESS cycles, readdata=0xDEADBEEF:
  - mem_read high 4 cycles; mem_address=0x100.
  - stall high until the completion cycle.
  - Bubbles in mem_out, then {1,rd,0xDEADBEEF}.
- LB at 0x103 and LBU at 0x103, readdata=0x80FF0011 -> wb_data 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202, data_2=0x0000ABCD -> mem_write=1, mem_address=0x200, mem_byteen=1100, mem_writedata=0xABCDABCD; mem_out write_reg_en=0.
- LW at 0x101 -> mem_misaligned pulse, no mem_read, stall=0, mem_out write_reg_en=0.
- reset asserted in the 2nd ACCESS cycle -> next edge: mem_read=0, mem_out=0, state IDLE; a later new access completes normally.
